// File: rtl/fpga_cfg_loader.sv
// Serial configuration loader feeding the fpga3x3 fabric.
// Hunts for a sync word, shifts in a CFG_WIDTH-bit payload (MSB first) into a
// shadow register, then compares a trailing popcount check field against the
// running popcount. The shadow is committed to `bitstream` only on a match.
//
// Ports:
//   clk        - system clock, rising edge
//   reset      - asynchronous, active-low reset
//   cfg_start  - one-cycle pulse, (re)arms the loader from any state
//   cfg_din    - serial configuration bit
//   cfg_valid  - cfg_din is valid this cycle
//   cfg_ready  - loader accepts a bit this cycle
//   bitstream  - last committed configuration
//   cfg_done   - last load committed successfully
//   cfg_error  - last load failed its check
//   fabric_en  - registered copy of cfg_done; fabric may run
module fpga_cfg_loader #(
    parameter int unsigned              CFG_WIDTH  = 116,
    parameter int unsigned              SYNC_WIDTH = 8,
    parameter logic [SYNC_WIDTH-1:0]    SYNC_WORD  = 8'hA5,
    parameter int unsigned              CHK_WIDTH  = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cfg_start,
    input  logic                 cfg_din,
    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    output logic [CFG_WIDTH-1:0] bitstream,
    output logic                 cfg_done,
    output logic                 cfg_error,
    output logic                 fabric_en
);

    // One counter serves both the payload and the check field.
    localparam int unsigned CNT_MAX = (CFG_WIDTH > CHK_WIDTH) ? CFG_WIDTH : CHK_WIDTH;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SYNC  = 3'd1,
        S_LOAD  = 3'd2,
        S_CHECK = 3'd3,
        S_DONE  = 3'd4,
        S_ERROR = 3'd5
    } state_t;

    state_t                 state_q;
    state_t                 next_state;

    logic [SYNC_WIDTH-1:0]  sync_q;
    logic [CFG_WIDTH-1:0]   shadow_q;
    logic [CHK_WIDTH-1:0]   chk_q;
    logic [CHK_WIDTH-1:0]   pop_q;
    logic [CNT_W-1:0]       cnt_q;

    logic                   accept_c;
    logic [SYNC_WIDTH-1:0]  sync_nxt_c;
    logic [CHK_WIDTH-1:0]   chk_nxt_c;
    logic                   load_last_c;
    logic                   chk_last_c;
    logic                   chk_ok_c;
    logic                   ready_nxt_c;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= next_state;
        end
    end

    // Next-state logic; cfg_start overrides everything, including a bit on the same edge
    always_comb begin
        next_state  = state_q;
        accept_c    = cfg_valid & cfg_ready;
        sync_nxt_c  = {sync_q[SYNC_WIDTH-2:0], cfg_din};
        chk_nxt_c   = {chk_q[CHK_WIDTH-2:0], cfg_din};
        load_last_c = (cnt_q == CNT_W'(CFG_WIDTH - 1));
        chk_last_c  = (cnt_q == CNT_W'(CHK_WIDTH - 1));
        chk_ok_c    = (chk_nxt_c == pop_q);
        ready_nxt_c = 1'b0;

        if (cfg_start) begin
            next_state = S_SYNC;
        end else begin
            case (state_q)
                S_IDLE: next_state = S_IDLE;
                S_SYNC: begin
                    if (accept_c && (sync_nxt_c == SYNC_WORD)) begin
                        next_state = S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (accept_c && load_last_c) begin
                        next_state = S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (accept_c && chk_last_c) begin
                        next_state = chk_ok_c ? S_DONE : S_ERROR;
                    end
                end
                S_DONE:  next_state = S_DONE;
                S_ERROR: next_state = S_ERROR;
                default: next_state = S_IDLE;
            endcase
        end

        // cfg_ready is registered from the next state so it always matches state_q
        ready_nxt_c = (next_state == S_SYNC) || (next_state == S_LOAD) ||
                      (next_state == S_CHECK);
    end

    // Datapath: sync window, shadow, check, popcount, counter and status outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q    <= '0;
            shadow_q  <= '0;
            chk_q     <= '0;
            pop_q     <= '0;
            cnt_q     <= '0;
            bitstream <= '0;
            cfg_done  <= 1'b0;
            cfg_error <= 1'b0;
            fabric_en <= 1'b0;
            cfg_ready <= 1'b0;
        end else begin
            cfg_ready <= ready_nxt_c;
            fabric_en <= cfg_done;

            if (cfg_start) begin
                // Re-arm: discard any partial frame, keep the last committed bitstream
                sync_q    <= '0;
                shadow_q  <= '0;
                chk_q     <= '0;
                pop_q     <= '0;
                cnt_q     <= '0;
                cfg_done  <= 1'b0;
                cfg_error <= 1'b0;
                fabric_en <= 1'b0;
            end else if (accept_c) begin
                case (state_q)
                    S_SYNC: begin
                        sync_q <= sync_nxt_c;
                        if (sync_nxt_c == SYNC_WORD) begin
                            cnt_q <= '0;
                            pop_q <= '0;
                        end
                    end
                    S_LOAD: begin
                        shadow_q <= {shadow_q[CFG_WIDTH-2:0], cfg_din};
                        pop_q    <= pop_q + CHK_WIDTH'(cfg_din);
                        cnt_q    <= load_last_c ? '0 : cnt_q + CNT_W'(1);
                    end
                    S_CHECK: begin
                        chk_q <= chk_nxt_c;
                        cnt_q <= cnt_q + CNT_W'(1);
                        if (chk_last_c) begin
                            if (chk_ok_c) begin
                                bitstream <= shadow_q;
                                cfg_done  <= 1'b1;
                                cfg_error <= 1'b0;
                            end else begin
                                cfg_done  <= 1'b0;
                                cfg_error <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        sync_q <= sync_q;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fpga_cfg_loader.sv
// Scoreboard bench for fpga_cfg_loader: stimulus pushes the expected
// completion of each frame, a monitor pops and compares on each rising
// cfg_done/cfg_error.
module tb_fpga_cfg_loader;

    localparam int unsigned W = 116;

    logic          clk;
    logic          reset;
    logic          cfg_start;
    logic          cfg_din;
    logic          cfg_valid;
    logic          cfg_ready;
    logic [W-1:0]  bitstream;
    logic          cfg_done;
    logic          cfg_error;
    logic          fabric_en;

    fpga_cfg_loader dut (
        .clk       (clk),
        .reset     (reset),
        .cfg_start (cfg_start),
        .cfg_din   (cfg_din),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .bitstream (bitstream),
        .cfg_done  (cfg_done),
        .cfg_error (cfg_error),
        .fabric_en (fabric_en)
    );

    typedef struct {
        logic         done;
        logic         err;
        logic [W-1:0] bits;
        int           lat;
    } exp_t;

    exp_t sb[$];
    exp_t e;

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   t0     = 0;
    logic prev_ev = 1'b0;
    logic ev;
    logic fen_pending = 1'b0;
    logic fen_exp = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: a rising done/error marks the completion of one frame
    always @(negedge clk) begin
        if (fen_pending) begin
            chk("fabric_en_next", 128'(fabric_en), 128'(fen_exp));
            fen_pending = 1'b0;
        end
        ev = cfg_done | cfg_error;
        if (ev && !prev_ev) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: got done=%0b error=%0b expected none",
                         cfg_done, cfg_error);
            end else begin
                e = sb.pop_front();
                chk("done",          128'(cfg_done),  128'(e.done));
                chk("error",         128'(cfg_error), 128'(e.err));
                chk("bitstream",     128'(bitstream), 128'(e.bits));
                chk("ready_at_end",  128'(cfg_ready), 128'(0));
                chk("fabric_en_end", 128'(fabric_en), 128'(0));
                chk("latency",       128'(cyc - t0),  128'(e.lat));
                fen_exp     = e.done;
                fen_pending = 1'b1;
            end
        end
        prev_ev = ev;
    end

    // All drive tasks are entered and left at posedge+1
    task automatic drive_bit(input logic b, input bit thr);
        cfg_valid = 1'b1;
        cfg_din   = b;
        @(posedge clk); #1;
        if (thr) begin
            cfg_valid = 1'b0;
            cfg_din   = 1'b0;
            @(posedge clk); #1;
        end
    endtask

    task automatic pulse_start();
        cfg_start = 1'b1;
        cfg_valid = 1'b0;
        @(posedge clk); #1;
        cfg_start = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] s, input logic [W-1:0] p,
                              input logic [7:0] c, input bit thr);
        for (int i = 7; i >= 0; i--)     drive_bit(s[i], thr);
        for (int i = W-1; i >= 0; i--)   drive_bit(p[i], thr);
        for (int i = 7; i >= 0; i--)     drive_bit(c[i], thr);
        cfg_valid = 1'b0;
        cfg_din   = 1'b0;
    endtask

    task automatic push(input logic d, input logic er, input logic [W-1:0] b, input int lat);
        exp_t x;
        x.done = d;
        x.err  = er;
        x.bits = b;
        x.lat  = lat;
        sb.push_back(x);
    endtask

    task automatic drain();
        for (int i = 0; i < 600; i++) begin
            if (sb.size() == 0 && !fen_pending) break;
            @(posedge clk); #1;
        end
        if (sb.size() != 0 || fen_pending) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
            sb.delete();
            fen_pending = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic chk_idle_outputs(input string tag, input logic [W-1:0] bs);
        chk({tag, "_bitstream"}, 128'(bitstream), 128'(bs));
        chk({tag, "_done"},      128'(cfg_done),  128'(0));
        chk({tag, "_error"},     128'(cfg_error), 128'(0));
        chk({tag, "_fabric_en"}, 128'(fabric_en), 128'(0));
    endtask

    logic [W-1:0] pay_fff;
    logic [W-1:0] pay_edge;
    logic [2:0]   junk;

    initial begin
        pay_fff  = W'(12'hFFF);
        pay_edge = '0;
        pay_edge[W-1] = 1'b1;
        pay_edge[1]   = 1'b1;
        pay_edge[0]   = 1'b1;
        junk = 3'b110;

        reset = 1'b0; cfg_start = 1'b0; cfg_din = 1'b0; cfg_valid = 1'b0;

        // Test 1: reset and idle
        repeat (3) @(posedge clk);
        #1;
        chk_idle_outputs("in_reset", '0);
        chk("in_reset_ready", 128'(cfg_ready), 128'(0));
        reset = 1'b1;
        @(posedge clk); #1;
        chk_idle_outputs("after_reset", '0);
        chk("after_reset_ready", 128'(cfg_ready), 128'(0));
        cfg_valid = 1'b1;
        cfg_din   = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        chk("idle_valid_ready", 128'(cfg_ready), 128'(0));
        chk_idle_outputs("idle_valid", '0);
        cfg_valid = 1'b0;
        cfg_din   = 1'b0;

        // Test 2: good load
        pulse_start();
        chk("sync_ready", 128'(cfg_ready), 128'(1));
        push(1'b1, 1'b0, pay_fff, 132);
        t0 = cyc;
        send_frame(8'hA5, pay_fff, 8'd12, 1'b0);
        drain();

        // Test 3: bad check keeps previous bitstream
        pulse_start();
        push(1'b0, 1'b1, pay_fff, 132);
        t0 = cyc;
        send_frame(8'hA5, '0, 8'h01, 1'b0);
        drain();

        // Test 4: sync hunting with leading junk
        pulse_start();
        push(1'b1, 1'b0, '0, 135);
        t0 = cyc;
        for (int i = 2; i >= 0; i--) drive_bit(junk[i], 1'b0);
        send_frame(8'hA5, '0, 8'h00, 1'b0);
        drain();

        // Test 5: abort mid-LOAD, start wins over a same-edge bit
        pulse_start();
        for (int i = 7; i >= 0; i--) drive_bit(8'hA5 >> i, 1'b0);
        for (int i = 0; i < 50; i++) drive_bit(1'b1, 1'b0);
        cfg_start = 1'b1;
        cfg_valid = 1'b1;
        cfg_din   = 1'b1;
        @(posedge clk); #1;
        cfg_start = 1'b0;
        cfg_valid = 1'b0;
        cfg_din   = 1'b0;
        chk("abort_ready", 128'(cfg_ready), 128'(1));
        chk_idle_outputs("abort", '0);
        push(1'b1, 1'b0, pay_edge, 132);
        t0 = cyc;
        send_frame(8'hA5, pay_edge, 8'd3, 1'b0);
        drain();

        // Test 6: throttled input, then async reset mid-LOAD
        pulse_start();
        push(1'b1, 1'b0, pay_fff, 263);
        t0 = cyc;
        send_frame(8'hA5, pay_fff, 8'd12, 1'b1);
        drain();
        pulse_start();
        for (int i = 7; i >= 0; i--) drive_bit(8'hA5 >> i, 1'b1);
        for (int i = 0; i < 20; i++) drive_bit(1'b1, 1'b1);
        #2;
        reset = 1'b0;
        #1;
        chk_idle_outputs("async_reset", '0);
        chk("async_reset_ready", 128'(cfg_ready), 128'(0));
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("post_reset_bitstream", 128'(bitstream), 128'(0));
        chk("post_reset_queue", 128'(sb.size()), 128'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fpga_cfg_loader.md
Name: fpga_cfg_loader

Overview:
- Serial configuration loader that sits directly upstream of the fpga3x3 fabric and drives its 116-bit `bitstream` port.
- Accepts a bit-serial frame: sync word, then payload, then an 8-bit popcount check.
- Assembles the payload in a shadow shift register and commits it to the fabric only when the check matches.
- Reports done/error status and gates the fabric enable.

Parameters:
CFG_WIDTH, 116, payload width in bits; equals the fpga3x3 `bitstream` width
SYNC_WORD, 8'hA5, frame start pattern, MSB first
SYNC_WIDTH, 8, width of SYNC_WORD
CHK_WIDTH, 8, width of the popcount check field

Ports:
clk  input  1  system clock; all logic on the rising edge
reset  input  1  asynchronous, active-low reset
cfg_start  input  1  one-cycle pulse; (re)arms the loader
cfg_din  input  1  serial config bit
cfg_valid  input  1  cfg_din is valid this cycle
cfg_ready  output  1  loader accepts a bit this cycle
bitstream  output  CFG_WIDTH  committed configuration to fpga3x3
cfg_done  output  1  last load committed successfully
cfg_error  output  1  last load failed its check
fabric_en  output  1  fabric may run; equals cfg_done

Behaviour:
- Accepted bit: cfg_valid & cfg_ready at a rising clk edge. A bit is never consumed without cfg_ready.
- Reset (reset=0, asynchronous): state=IDLE; bitstream=0; shadow=0; counters=0; sync window=0; cfg_ready=0; cfg_done=0; cfg_error=0; fabric_en=0.
  - Reset mid-frame discards the partial frame.
- States and transitions:
  - IDLE: cfg_ready=0. cfg_start -> SYNC.
  - SYNC: cfg_ready=1. Each accepted bit shifts into an 8-bit window, LSB in. When the window after the shift equals SYNC_WORD -> LOAD, with bit count=0 and popcount=0. Bits that do not complete a match are dropped silently; there is no timeout.
  - LOAD: cfg_ready=1. Each accepted bit does shadow <= {shadow[CFG_WIDTH-2:0], cfg_din} and popcount <= popcount + cfg_din.
    - Popcount is 8 bits and wraps at 256, which is unreachable for 116 bits.
    - Payload is MSB first: the first payload bit ends in bitstream[115].
    - The 116th accepted bit -> CHECK.
  - CHECK: cfg_ready=1. Accepted bits shift into an 8-bit check register, MSB first. On the edge that accepts the 8th bit, the full check value is compared with popcount:
    - Equal: bitstream <= shadow, cfg_done <= 1, cfg_error <= 0 -> DONE.
    - Not equal: bitstream unchanged, cfg_done <= 0, cfg_error <= 1 -> ERROR.
  - DONE / ERROR: cfg_ready=0; outputs hold. cfg_start -> SYNC.
- Latency: bitstream, cfg_done and cfg_error update on the same edge that accepts the last check bit. Minimum frame is 8+116+8=132 accepted bits, so DONE is reached 132 cycles after the first sync bit with cfg_valid held high.
- cfg_start in any state, including mid-LOAD or mid-CHECK:
  - Next state is SYNC.
  - The sync window, counters, shadow and check register clear.
  - cfg_done, cfg_error and fabric_en clear.
  - bitstream keeps its last committed value until the next successful commit.
- cfg_start and an accepted bit on the same edge: cfg_start wins and the bit is discarded.
- cfg_valid gaps: the state and counters simply hold; there is no limit on gap length.
- fabric_en is cfg_done, registered. The fabric must be treated as unconfigured while fabric_en=0.

Test Plan:
1. Reset and idle: hold reset=0 for 3 cycles, then release -> all outputs 0, cfg_ready=0. Drive cfg_valid=1 with no cfg_start -> bitstream remains 0.
2. Good load: cfg_start; send 8'hA5, then payload 116'hFFF (MSB first), then check 8'd12, cfg_valid=1 throughout -> on the edge accepting the 132nd bit, bitstream=116'hFFF, cfg_done=1, fabric_en=1 (next cycle), cfg_error=0, cfg_ready=0.
3. Bad check: after test 2, cfg_start; send 8'hA5, payload 116'h0, check 8'h01 -> cfg_error=1, cfg_done=0, bitstream still 116'hFFF.
4. Sync hunting: cfg_start; send 3'b110, then 8'hA5, then a payload of all zeros with check 8'h00 -> the leading junk is ignored, the load succeeds, bitstream=0.
5. Abort: cfg_start; send the sync word and 50 payload bits, then pulse cfg_start together with cfg_valid=1 -> state returns to SYNC, the bit on that edge is dropped, cfg_done=0, bitstream holds its prior value. A full good frame afterwards commits correctly.
6. Throttled input: repeat test 2 with cfg_valid toggling 1/0 every cycle -> identical result, committed 263 cycles after the first valid bit; async reset asserted mid-LOAD clears all outputs immediately.
